// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_if
//  Description : Host handshake and SPI pin bundle for spi_master_fsm.
//                The master modport is the controller's view; the slave
//                modport is the view of whatever drives the host side and
//                the miso pin.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        mode;
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              miso;
  logic              cs;
  logic              sclk;
  logic              mosi;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (
    input  mode, start, tx_data, miso,
    output cs, sclk, mosi, busy, done, rx_data
  );

  modport slave (
    output mode, start, tx_data, miso,
    input  cs, sclk, mosi, busy, done, rx_data
  );
endinterface
`default_nettype wire

// File: rtl/spi_master_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_fsm
//  Description : SPI master supporting all four modes. Shifts DATA_W bits
//                MSB first on mosi, captures miso, start/busy/done host
//                handshake. Every output comes straight from a flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_fsm #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  wire logic   clk,
  input  wire logic   reset,
  spi_master_if.master bus
);

  localparam int EDGES  = 2 * DATA_W;
  localparam int EDGE_W = $clog2(EDGES + 1);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST    = EDGE_W'(EDGES);
  localparam logic [EDGE_W-1:0] EDGE_ADV_MAX = EDGE_W'(EDGES - 2);
  localparam logic [EDGE_W-1:0] EDGE_ADV_MIN = EDGE_W'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic                cpha_q, cpha_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic                cs_q, cs_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;

  logic                div_tick;
  logic [EDGE_W-1:0]   edge_k;
  logic                do_sample;
  logic                do_shift;

  // State register; reset drops any transfer in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      cpha_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      cpha_q     <= cpha_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Next-state and next-output logic; one sclk edge per CLK_DIV-cycle tick.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    cpha_d     = cpha_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rx_data_d  = rx_data_q;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    div_tick   = (div_cnt_q == DIV_LAST);
    edge_k     = edge_cnt_q + EDGE_W'(1);

    unique case (state_q)
      IDLE: begin
        cs_d       = 1'b1;
        busy_d     = 1'b0;
        mosi_d     = 1'b0;
        sclk_d     = bus.mode[1];
        div_cnt_d  = '0;
        edge_cnt_d = '0;
        if (bus.start) begin
          state_d = LEAD;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cpha_d  = bus.mode[0];
          tx_sr_d = bus.tx_data;
          rx_sr_d = '0;
          mosi_d  = bus.tx_data[DATA_W-1];
        end
      end

      LEAD, XFER: begin
        if (div_tick) begin
          div_cnt_d  = '0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_k;
          // Odd edges lead, even edges trail; CPHA picks which one samples.
          if (edge_k[0]) begin
            if (!cpha_q)                    do_sample = 1'b1;
            else if (edge_k >= EDGE_ADV_MIN) do_shift  = 1'b1;
          end else begin
            if (cpha_q)                      do_sample = 1'b1;
            else if (edge_k <= EDGE_ADV_MAX) do_shift  = 1'b1;
          end
          state_d = (edge_k == EDGE_LAST) ? TRAIL : XFER;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      TRAIL: begin
        if (div_tick) begin
          state_d    = IDLE;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          cs_d       = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sr_q;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (do_sample) begin
      rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.miso};
    end
    // mosi always mirrors the top bit of the shift register, so it moves
    // to the bit just below it as the register shifts.
    if (do_shift) begin
      tx_sr_d = tx_sr_q << 1;
      mosi_d  = tx_sr_q[DATA_W-2];
    end
  end

  assign bus.cs      = cs_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_fsm
//  Description : Scoreboard bench for spi_master_fsm (DATA_W=8, CLK_DIV=2).
//                Stimulus pushes expected words; a monitor acting as an SPI
//                slave model checks each done pulse against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_fsm;

  logic clk;
  logic reset;
  logic loop_en;
  logic miso_fix;

  spi_master_if #(.DATA_W(8)) bus ();

  spi_master_fsm #(.DATA_W(8), .CLK_DIV(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.miso = loop_en ? bus.mosi : miso_fix;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    logic [1:0] mode;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave-side model: counts cs-low cycles and sclk edges, samples mosi on
  // the edge its CPHA says, then checks everything when done appears.
  int         cs_low, n_edges;
  logic       sclk_prev, mosi_prev, first_lvl;
  logic [7:0] mosi_seq;
  always @(negedge clk) begin
    if (reset) begin
      cs_low = 0; n_edges = 0; mosi_seq = 8'h00; first_lvl = 1'b0;
    end else begin
      if (!bus.cs) cs_low++;
      if (!bus.cs && bus.sclk !== sclk_prev) begin
        n_edges++;
        if (n_edges == 1) first_lvl = sclk_prev;
        if (sb.size() > 0) begin
          if ((n_edges % 2 == 1) == (sb[0].mode[0] == 1'b0))
            mosi_seq = {mosi_seq[6:0], mosi_prev};
        end
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rx_data", bus.rx_data, e.rx);
          check("busy_at_done", bus.busy, 0);
          check("cs_at_done", bus.cs, 1);
          check("sclk_edges", n_edges, 16);
          check("cs_low_cycles", cs_low, 34);
          check("mosi_sequence", mosi_seq, e.tx);
          check("first_edge_level", first_lvl, e.mode[1]);
        end
        cs_low = 0; n_edges = 0; mosi_seq = 8'h00;
      end
    end
    sclk_prev = bus.sclk;
    mosi_prev = bus.mosi;
  end

  task automatic run_xfer(input logic [1:0] m, input logic [7:0] tx,
                          input logic lp, input logic mf, input logic [7:0] exp_rx);
    exp_t e;
    bit   ok;
    @(negedge clk);
    bus.mode = m; loop_en = lp; miso_fix = mf;
    @(negedge clk);
    @(negedge clk);
    check("idle_sclk", bus.sclk, m[1]);
    e.rx = exp_rx; e.tx = tx; e.mode = m;
    sb.push_back(e);
    bus.tx_data = tx; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("accept_cs", bus.cs, 0);
    check("accept_busy", bus.busy, 1);
    check("accept_mosi", bus.mosi, tx[7]);
    check("accept_sclk", bus.sclk, m[1]);
    ok = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        check("done_latency", i, 34);
        break;
      end
      if (i == 10) bus.start = 1'b1;
      if (i == 11) bus.start = 1'b0;
      if (i == 12) begin bus.tx_data = ~tx; bus.mode = {m[1], ~m[0]}; end
      if (i == 25) begin bus.tx_data = tx; bus.mode = m; end
    end
    if (!ok) check("done_timeout", 0, 1);
    @(negedge clk);
    check("idle_sclk_after", bus.sclk, m[1]);
    check("idle_mosi_after", bus.mosi, 0);
  endtask

  initial begin
    bit ok;
    int j;
    reset = 1'b1; loop_en = 1'b1; miso_fix = 1'b0;
    bus.mode = 2'b00; bus.start = 1'b0; bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs", bus.cs, 1);
    check("rst_sclk", bus.sclk, 0);
    check("rst_mosi", bus.mosi, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rx_data", bus.rx_data, 0);
    reset = 1'b0;

    run_xfer(2'd0, 8'hA5, 1'b1, 1'b0, 8'hA5);
    run_xfer(2'd1, 8'h3C, 1'b0, 1'b1, 8'hFF);
    run_xfer(2'd2, 8'h81, 1'b1, 1'b0, 8'h81);
    run_xfer(2'd3, 8'h81, 1'b1, 1'b0, 8'h81);

    // Back-to-back transfers with start held high.
    @(negedge clk);
    bus.mode = 2'd0; loop_en = 1'b1;
    @(negedge clk);
    begin
      exp_t e;
      e.rx = 8'h12; e.tx = 8'h12; e.mode = 2'd0; sb.push_back(e);
      e.rx = 8'h34; e.tx = 8'h34; e.mode = 2'd0; sb.push_back(e);
    end
    bus.tx_data = 8'h12; bus.start = 1'b1;
    @(negedge clk);
    check("b2b_first_cs", bus.cs, 0);
    bus.tx_data = 8'h34;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1'b1; break; end
    end
    if (!ok) check("b2b_done1_timeout", 0, 1);
    @(negedge clk);
    check("b2b_second_cs", bus.cs, 0);
    check("b2b_second_busy", bus.busy, 1);
    bus.start = 1'b0;
    ok = 1'b0; j = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      j++;
      if (bus.done) begin ok = 1'b1; break; end
    end
    if (!ok) check("b2b_done2_timeout", 0, 1);
    check("b2b_done_spacing", j, 35);

    // Reset in the middle of a mode 0 transfer.
    @(negedge clk);
    bus.tx_data = 8'h5A; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_started", bus.cs, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs", bus.cs, 1);
    check("abort_sclk", bus.sclk, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_rx_data", bus.rx_data, 0);
    reset = 1'b0;
    run_xfer(2'd0, 8'hC3, 1'b1, 1'b0, 8'hC3);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/spi_master_fsm.md
Name: spi_master_fsm

Overview:
SPI master (initiator) for the slave-side SPI FSM. It generates cs and sclk in all four SPI modes, shifts a DATA_W-bit word out on mosi and captures the word returned on miso. A host drives it with a start/busy/done handshake. It sits between a local register/control block and the SPI pins, and drives the bus that the slave FSM's cs/sclk inputs listen to.

Parameters:
DATA_W, 8, bits per transfer, MSB first; legal range >= 2.
CLK_DIV, 2, clk cycles per sclk half-period; legal range >= 1.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
mode  input  2  SPI mode. mode[1] = CPOL (sclk idle level). mode[0] = CPHA (0: sample on leading edge; 1: shift on leading edge).
start  input  1  transfer request; sampled only in IDLE.
tx_data  input  DATA_W  word to send; latched when start is accepted.
miso  input  1  serial data from the slave.
cs  output  1  chip select, active low.
sclk  output  1  serial clock.
mosi  output  1  serial data to the slave.
busy  output  1  high while a transfer is in progress.
done  output  1  one-cycle pulse at the end of a transfer.
rx_data  output  DATA_W  received word; updated only with done.

Behaviour:
- Reset values (sampled reset=1 at posedge): cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, state=IDLE, counters=0. Reset mid-transfer aborts the transfer at once. No done pulse is produced and rx_data is cleared.
- All outputs are registered.
- States: IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
- IDLE:
  - cs=1, busy=0.
  - sclk follows mode[1], registered, so it has 1 cycle of latency.
  - mosi=0.
  - start=1 at a posedge accepts a transfer. On that edge, latch mode and tx_data into a shift register. The next outputs are cs=0, busy=1, mosi=tx_data[DATA_W-1] (both CPHA values) and sclk=CPOL. Call this edge T0.
- LEAD: hold for CLK_DIV cycles. Then enter XFER and produce sclk edge 1.
- XFER:
  - Toggle sclk every CLK_DIV cycles, giving edges k=1..2*DATA_W. Edge k appears at T0 + k*CLK_DIV.
  - Odd edges are leading edges; even edges are trailing edges.
  - CPHA=0: on leading edges, shift the miso value present just before the edge into the receive register, LSB side. On trailing edges 2..2*DATA_W-2, advance mosi to the next bit. After the final trailing edge, mosi holds the LSB.
  - CPHA=1: on leading edge 1, mosi keeps the MSB. On leading edges 3..2*DATA_W-1, advance mosi. Sample miso on trailing edges.
  - In both modes exactly DATA_W samples are taken.
  - After edge 2*DATA_W, sclk equals CPOL. Enter TRAIL.
- TRAIL:
  - Hold for CLK_DIV cycles.
  - At T0 + (2*DATA_W+1)*CLK_DIV: cs=1, busy=0, done=1 for 1 cycle, rx_data = receive register, mosi=0, state=IDLE.
- Latency: for the defaults, cs is low from T0 to T0+33, and done is high in cycle T0+34.
- Handshake rules:
  - start while busy=1 is ignored.
  - start in the done cycle is accepted (state is already IDLE). This gives back-to-back transfers with cs high for exactly 1 cycle.
  - Changes on mode or tx_data during a transfer have no effect.
  - A mode change in IDLE only moves the idle level of sclk.
- Data integrity: sclk never glitches; edge spacing is exactly CLK_DIV cycles. Holding start high continuously gives continuous back-to-back transfers.
- CLK_DIV=1: sclk toggles every clk cycle; all timing formulas still hold.

Test Plan:
- Mode 0, CLK_DIV=2, tx_data=0xA5, miso tied to mosi -> cs low at T0..T0+33; 16 sclk edges starting low; mosi sequence 1,0,1,0,0,1,0,1; done at T0+34; rx_data=0xA5; busy low with done.
- Mode 1, tx_data=0x3C, miso held 1 -> mosi updates on rising edges; rx_data=0xFF; sclk idle 0 before and after.
- Mode 2 and mode 3, tx_data=0x81, loopback -> sclk idles 1 (two cycles after the mode write); first edge falling; rx_data=0x81 in both.
- start held high for 2 transfers (0x12, then 0x34), loopback -> second cs fall exactly 1 cycle after the first cs rise; two done pulses 35 cycles apart; rx_data 0x12, then 0x34; start pulses while busy produce no extra transfer.
- Reset asserted at T0+10 of a mode 0 transfer -> next cycle cs=1, sclk=0, busy=0, rx_data=0, no done pulse; a new start is accepted normally.
- Instantiate the slave spi_fsm on cs/sclk/mode for all 4 modes -> its shift/sample pulses occur exactly DATA_W times each and align with the master's shift and sample edges.
